// File: rtl/pipe_ctrl_pkg.sv
// Shared types, forwarding-select encodings and helpers for the pipeline hazard controller.
// Also holds the sizing function for the occupancy counter.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_MD_BUSY   = 2'd1,
    ST_SYS_DRAIN = 2'd2
  } ctrl_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // The counter must hold the largest latency value.
  function automatic int cnt_width(input int mult_lat, input int div_lat, input int drain_lat);
    return $clog2(max3(mult_lat, div_lat, drain_lat) + 1);
  endfunction

  // $zero is hard-wired, so a write to register 0 never creates a dependency.
  function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
    return (dst != 5'd0) && (dst == src);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// Purely combinational forwarding selects and data-hazard detection.
// Covers load-use and branch-compare hazards.
module fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  input  logic [4:0] rs_e,
  input  logic [4:0] rt_e,
  input  logic [4:0] write_reg_e,
  input  logic [4:0] write_reg_m,
  input  logic [4:0] write_reg_w,
  input  logic       reg_write_e,
  input  logic       reg_write_m,
  input  logic       reg_write_w,
  input  logic       mem_to_reg_e,
  input  logic       mem_to_reg_m,
  input  logic       branch_d,
  output logic [1:0] fwd_a_e,
  output logic [1:0] fwd_b_e,
  output logic       fwd_a_d,
  output logic       fwd_b_d,
  output logic       lwstall,
  output logic       brstall
);

  // M holds the younger result, so it wins over W.
  function automatic logic [1:0] e_sel(input logic [4:0] src,
                                       input logic       wr_m,
                                       input logic [4:0] dst_m,
                                       input logic       wr_w,
                                       input logic [4:0] dst_w);
    logic [1:0] sel;
    sel = FWD_RF;
    if (wr_m && reg_match(dst_m, src)) begin
      sel = FWD_MEM;
    end else if (wr_w && reg_match(dst_w, src)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

  logic e_hits_d;
  logic m_hits_d;

  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    fwd_a_e  = e_sel(rs_e, reg_write_m, write_reg_m, reg_write_w, write_reg_w);
    fwd_b_e  = e_sel(rt_e, reg_write_m, write_reg_m, reg_write_w, write_reg_w);
    fwd_a_d  = reg_write_m && reg_match(write_reg_m, rs_d);
    fwd_b_d  = reg_write_m && reg_match(write_reg_m, rt_d);

    e_hits_d = reg_match(write_reg_e, rs_d) || reg_match(write_reg_e, rt_d);
    m_hits_d = reg_match(write_reg_m, rs_d) || reg_match(write_reg_m, rt_d);

    lwstall  = mem_to_reg_e && e_hits_d;
    // The branch compares in D, so it waits for any E result and for a load still in M.
    brstall  = branch_d && ((reg_write_e && e_hits_d) || (mem_to_reg_m && m_hits_d));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and stall sequencer for the 5-stage MIPS pipeline.
// Tracks mult/div occupancy and syscall drain, holding the front end until each completes.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_LAT  = 4,
  parameter int DIV_LAT   = 32,
  parameter int DRAIN_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  input  logic [4:0] rs_e,
  input  logic [4:0] rt_e,
  input  logic [4:0] write_reg_e,
  input  logic [4:0] write_reg_m,
  input  logic [4:0] write_reg_w,
  input  logic       reg_write_e,
  input  logic       reg_write_m,
  input  logic       reg_write_w,
  input  logic       mem_to_reg_e,
  input  logic       mem_to_reg_m,
  input  logic       branch_d,
  input  logic       md_use_d,
  input  logic       md_start_e,
  input  logic       md_is_div,
  input  logic       syscall_e,
  output logic       stall_f,
  output logic       stall_d,
  output logic       flush_e,
  output logic       fwd_a_d,
  output logic       fwd_b_d,
  output logic [1:0] fwd_a_e,
  output logic [1:0] fwd_b_e,
  output logic       md_busy,
  output logic       md_done,
  output logic       syscall_go
);

  localparam int CNT_W = cnt_width(MULT_LAT, DIV_LAT, DRAIN_LAT);

  localparam logic [CNT_W-1:0] MULT_LOAD  = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD   = CNT_W'(DIV_LAT - 1);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_LAT - 1);

  ctrl_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sys_pend_q;

  logic [1:0] fwd_a_e_raw;
  logic [1:0] fwd_b_e_raw;
  logic       fwd_a_d_raw;
  logic       fwd_b_d_raw;
  logic       lwstall;
  logic       brstall;

  fwd_unit u_fwd (
    .rs_d         (rs_d),
    .rt_d         (rt_d),
    .rs_e         (rs_e),
    .rt_e         (rt_e),
    .write_reg_e  (write_reg_e),
    .write_reg_m  (write_reg_m),
    .write_reg_w  (write_reg_w),
    .reg_write_e  (reg_write_e),
    .reg_write_m  (reg_write_m),
    .reg_write_w  (reg_write_w),
    .mem_to_reg_e (mem_to_reg_e),
    .mem_to_reg_m (mem_to_reg_m),
    .branch_d     (branch_d),
    .fwd_a_e      (fwd_a_e_raw),
    .fwd_b_e      (fwd_b_e_raw),
    .fwd_a_d      (fwd_a_d_raw),
    .fwd_b_d      (fwd_b_d_raw),
    .lwstall      (lwstall),
    .brstall      (brstall)
  );

  logic cnt_zero;
  logic in_md;
  logic in_drain;
  logic stall_raw;

  assign cnt_zero  = (cnt_q == '0);
  assign in_md     = (state_q == ST_MD_BUSY);
  assign in_drain  = (state_q == ST_SYS_DRAIN);
  assign stall_raw = lwstall | brstall | (in_md & md_use_d) | in_drain;

  // Outputs are forced to their reset values for the whole time rst is high,
  // including the first cycle before the synchronous reset has taken effect.
  assign stall_f    = ~rst & stall_raw;
  assign stall_d    = ~rst & stall_raw;
  assign flush_e    = rst | stall_raw;
  assign fwd_a_d    = ~rst & fwd_a_d_raw;
  assign fwd_b_d    = ~rst & fwd_b_d_raw;
  assign fwd_a_e    = rst ? FWD_RF : fwd_a_e_raw;
  assign fwd_b_e    = rst ? FWD_RF : fwd_b_e_raw;
  assign md_busy    = ~rst & in_md;
  assign md_done    = ~rst & in_md & cnt_zero;
  assign syscall_go = ~rst & in_drain & cnt_zero;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      cnt_q      <= '0;
      sys_pend_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (syscall_e) begin
            state_q <= ST_SYS_DRAIN;
            cnt_q   <= DRAIN_LOAD;
          end else if (md_start_e) begin
            state_q <= ST_MD_BUSY;
            cnt_q   <= md_is_div ? DIV_LOAD : MULT_LOAD;
          end
        end
        ST_MD_BUSY: begin
          // A syscall passing E now is remembered and drained once the unit frees up.
          if (cnt_zero) begin
            if (sys_pend_q || syscall_e) begin
              state_q    <= ST_SYS_DRAIN;
              cnt_q      <= DRAIN_LOAD;
              sys_pend_q <= 1'b0;
            end else begin
              state_q <= ST_RUN;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (syscall_e) begin
              sys_pend_q <= 1'b1;
            end
          end
        end
        ST_SYS_DRAIN: begin
          if (cnt_zero) begin
            state_q <= ST_RUN;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_RUN;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: each driven cycle pushes its expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs_d, rt_d, rs_e, rt_e;
  logic [4:0] write_reg_e, write_reg_m, write_reg_w;
  logic       reg_write_e, reg_write_m, reg_write_w;
  logic       mem_to_reg_e, mem_to_reg_m, branch_d;
  logic       md_use_d, md_start_e, md_is_div, syscall_e;
  logic       stall_f, stall_d, flush_e, fwd_a_d, fwd_b_d;
  logic [1:0] fwd_a_e, fwd_b_e;
  logic       md_busy, md_done, syscall_go;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MULT_LAT(4), .DIV_LAT(32), .DRAIN_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
    .write_reg_e(write_reg_e), .write_reg_m(write_reg_m), .write_reg_w(write_reg_w),
    .reg_write_e(reg_write_e), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .mem_to_reg_e(mem_to_reg_e), .mem_to_reg_m(mem_to_reg_m), .branch_d(branch_d),
    .md_use_d(md_use_d), .md_start_e(md_start_e), .md_is_div(md_is_div), .syscall_e(syscall_e),
    .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e),
    .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d), .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
    .md_busy(md_busy), .md_done(md_done), .syscall_go(syscall_go)
  );

  typedef struct {
    string       tag;
    logic [11:0] val;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  logic [11:0] obs;
  assign obs = {stall_f, stall_d, flush_e, fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e,
                md_busy, md_done, syscall_go};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (stl,stl,fl,fad,fbd,fae,fbe,bsy,dn,go)", tag, got, want);
    end
  endtask

  function automatic logic [11:0] ev(input logic stall, input logic flush,
                                     input logic fad, input logic fbd,
                                     input logic [1:0] fa, input logic [1:0] fb,
                                     input logic busy, input logic done, input logic go);
    return {stall, stall, flush, fad, fbd, fa, fb, busy, done, go};
  endfunction

  localparam logic [11:0] IDLE = 12'h000;

  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      check(mon_e.tag, 32'(obs), 32'(mon_e.val));
    end
  end

  task automatic tick(input string tag, input logic [11:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rs_d = 0; rt_d = 0; rs_e = 0; rt_e = 0;
    write_reg_e = 0; write_reg_m = 0; write_reg_w = 0;
    reg_write_e = 0; reg_write_m = 0; reg_write_w = 0;
    mem_to_reg_e = 0; mem_to_reg_m = 0; branch_d = 0;
    md_use_d = 0; md_start_e = 0; md_is_div = 0; syscall_e = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    // Forwarding-worthy inputs during reset must still leave fwd outputs at 0.
    reg_write_m = 1; write_reg_m = 5; rs_e = 5; rs_d = 5;
    @(posedge clk); #1;
    tick("rst0", ev(0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    tick("rst1", ev(0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    rst = 1'b0;
    idle_inputs();
    tick("idle", IDLE);

    // Load followed by dependent ALU op: exactly one bubble, then M->D forward.
    mem_to_reg_e = 1; write_reg_e = 8; rs_d = 8;
    tick("lw_stall", ev(1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    mem_to_reg_e = 0; write_reg_e = 0;
    mem_to_reg_m = 1; reg_write_m = 1; write_reg_m = 8;
    tick("lw_after", ev(0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0));
    idle_inputs();
    mem_to_reg_e = 1; write_reg_e = 0; rs_d = 0;
    tick("lw_r0", IDLE);
    idle_inputs();

    // E-stage forwarding priority.
    reg_write_m = 1; reg_write_w = 1; write_reg_m = 5; write_reg_w = 5; rs_e = 5;
    tick("fwd_mem", ev(0, 0, 0, 0, 2'b10, 2'b00, 0, 0, 0));
    write_reg_m = 0;
    tick("fwd_wb", ev(0, 0, 0, 0, 2'b01, 2'b00, 0, 0, 0));
    rs_e = 0;
    tick("fwd_r0", IDLE);
    rt_e = 7; write_reg_w = 7; reg_write_m = 0;
    tick("fwd_b_wb", ev(0, 0, 0, 0, 2'b00, 2'b01, 0, 0, 0));
    reg_write_w = 0;
    tick("fwd_b_nowr", IDLE);
    idle_inputs();

    // Branch hazards.
    branch_d = 1; reg_write_e = 1; write_reg_e = 3; rt_d = 3;
    tick("br_e", ev(1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    branch_d = 0;
    tick("nobr_e", IDLE);
    idle_inputs();
    branch_d = 1; mem_to_reg_m = 1; reg_write_m = 1; write_reg_m = 4; rs_d = 4;
    tick("br_m_ld", ev(1, 1, 1, 0, 2'b00, 2'b00, 0, 0, 0));
    mem_to_reg_m = 0;
    tick("br_m_alu", ev(0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0));
    idle_inputs();

    // Syscall in RUN; a second syscall in E during the drain is ignored.
    syscall_e = 1;
    tick("sys0", IDLE);
    tick("sys1", ev(1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    syscall_e = 0;
    tick("sys2", ev(1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 1));
    tick("sys3", IDLE);
    tick("sys4", IDLE);

    // DIV with dependent MFHI in D.
    md_start_e = 1; md_is_div = 1; md_use_d = 1;
    tick("div0", IDLE);
    md_start_e = 0; md_is_div = 0;
    for (int i = 1; i <= 32; i++) begin
      tick($sformatf("div%0d", i), ev(1, 1, 0, 0, 2'b00, 2'b00, 1, (i == 32), 0));
    end
    tick("div33", IDLE);
    idle_inputs();
    tick("div34", IDLE);

    // MULT with a syscall arriving mid-operation.
    md_start_e = 1;
    tick("ms0", IDLE);
    md_start_e = 0;
    tick("ms1", ev(0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 0));
    syscall_e = 1;
    tick("ms2", ev(0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 0));
    syscall_e = 0;
    tick("ms3", ev(0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 0));
    tick("ms4", ev(0, 0, 0, 0, 2'b00, 2'b00, 1, 1, 0));
    tick("ms5", ev(1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    tick("ms6", ev(1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 1));
    tick("ms7", IDLE);

    // Reset in the middle of a DIV abandons it without a done pulse.
    md_start_e = 1; md_is_div = 1;
    tick("rd0", IDLE);
    md_start_e = 0; md_is_div = 0;
    for (int i = 1; i <= 4; i++) begin
      tick($sformatf("rd%0d", i), ev(0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 0));
    end
    rst = 1'b1;
    tick("rd_rst", ev(0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    rst = 1'b0;
    for (int i = 6; i <= 36; i++) begin
      tick($sformatf("rd%0d", i), IDLE);
    end

    @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
